// File: rtl/axis_iter_div_if.sv
// Operand/result stream bundle between the EXE mul/div unit and the iterative divider.
// Latency: none (wiring only).
// Backpressure: operand channels share one tready; the result channel has no tready and must be sampled on the pulse.
interface axis_iter_div_if #(
  parameter int WIDTH = 32
);
  logic               s_axis_dividend_tvalid;
  logic               s_axis_dividend_tready;
  logic [WIDTH-1:0]   s_axis_dividend_tdata;
  logic               s_axis_divisor_tvalid;
  logic               s_axis_divisor_tready;
  logic [WIDTH-1:0]   s_axis_divisor_tdata;
  logic               m_axis_dout_tvalid;
  logic [2*WIDTH-1:0] m_axis_dout_tdata;

  // Requester side (EXE-stage unit)
  modport master (
    output s_axis_dividend_tvalid, s_axis_dividend_tdata,
    output s_axis_divisor_tvalid,  s_axis_divisor_tdata,
    input  s_axis_dividend_tready, s_axis_divisor_tready,
    input  m_axis_dout_tvalid,     m_axis_dout_tdata
  );

  // Responder side (divider)
  modport slave (
    input  s_axis_dividend_tvalid, s_axis_dividend_tdata,
    input  s_axis_divisor_tvalid,  s_axis_divisor_tdata,
    output s_axis_dividend_tready, s_axis_divisor_tready,
    output m_axis_dout_tvalid,     m_axis_dout_tdata
  );
endinterface

// File: rtl/axis_iter_div.sv
// Iterative radix-2 restoring divider (DIV when SIGNED=1, DIVU when SIGNED=0); result {quotient, remainder}.
// Latency: result pulse WIDTH+1 cycles after the handshake (1 cycle for trivial operands when DIV_FASTPATH_EN is defined).
// Backpressure: shared tready is high only when idle and not in rst/flush; the result pulse has no tready.
module axis_iter_div #(
  parameter bit SIGNED = 1'b1,
  parameter int WIDTH  = 32
) (
  input logic            clk,
  input logic            rst,
  input logic            flush,
  axis_iter_div_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] quo_q;      // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] rem_q;      // partial remainder
  logic [WIDTH-1:0] dvs_q;      // divisor magnitude
  logic             sign_q_q;
  logic             sign_r_q;
  logic             dout_vld_q;
  logic [2*WIDTH-1:0] dout_dat_q;

  logic             rdy;
  logic             hs;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             step_ok;
  logic [WIDTH-1:0] rem_step, quo_step;

  logic             fast_take;
  logic [WIDTH-1:0] fast_quo, fast_rem;

  logic [WIDTH-1:0] raw_quo, raw_rem;
  logic             fix_q, fix_r;
  logic [WIDTH-1:0] res_quo, res_rem;

  // Shared ready: only an idle divider that is not being reset or flushed accepts operands.
  assign rdy = (state_q == IDLE) && !rst && !flush;
  assign hs  = rdy && bus.s_axis_dividend_tvalid && bus.s_axis_divisor_tvalid;

  assign bus.s_axis_dividend_tready = rdy;
  assign bus.s_axis_divisor_tready  = rdy;
  assign bus.m_axis_dout_tvalid     = dout_vld_q;
  assign bus.m_axis_dout_tdata      = dout_dat_q;

  // Operand magnitudes; the most negative value keeps its bit pattern, which is its correct unsigned magnitude.
  assign a_neg = SIGNED && bus.s_axis_dividend_tdata[WIDTH-1];
  assign b_neg = SIGNED && bus.s_axis_divisor_tdata[WIDTH-1];
  assign a_mag = a_neg ? -bus.s_axis_dividend_tdata : bus.s_axis_dividend_tdata;
  assign b_mag = b_neg ? -bus.s_axis_divisor_tdata  : bus.s_axis_divisor_tdata;

  // One restoring step: shift {rem, quo} left, trial-subtract with one guard bit.
  assign rem_sh   = {rem_q, quo_q[WIDTH-1]};
  assign diff     = rem_sh - {1'b0, dvs_q};
  assign step_ok  = !diff[WIDTH];
  assign rem_step = step_ok ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign quo_step = {quo_q[WIDTH-2:0], step_ok};

`ifdef DIV_FASTPATH_EN
  // Trivial operands: the iterative loop would produce exactly these values.
  assign fast_take = (b_mag == '0) || (a_mag < b_mag);
  assign fast_quo  = (b_mag == '0) ? '1 : '0;
  assign fast_rem  = a_mag;
`else
  assign fast_take = 1'b0;
  assign fast_quo  = '0;
  assign fast_rem  = '0;
`endif

  // Result source: the fast path resolves from the live operands in IDLE, otherwise the final CALC step.
  assign raw_quo = (state_q == IDLE) ? fast_quo : quo_step;
  assign raw_rem = (state_q == IDLE) ? fast_rem : rem_step;
  assign fix_q   = (state_q == IDLE) ? (a_neg ^ b_neg) : sign_q_q;
  assign fix_r   = (state_q == IDLE) ? a_neg : sign_r_q;
  assign res_quo = fix_q ? -raw_quo : raw_quo;
  assign res_rem = fix_r ? -raw_rem : raw_rem;

  // Next-state logic; flush abandons whatever is in flight.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (hs) state_d = fast_take ? DONE : CALC;
      CALC: if (count_q == '0) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Operand latch on handshake, then one restoring step per CALC cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      sign_q_q <= 1'b0;
      sign_r_q <= 1'b0;
    end else if (hs) begin
      count_q  <= CW'(WIDTH - 1);
      quo_q    <= a_mag;
      rem_q    <= '0;
      dvs_q    <= b_mag;
      sign_q_q <= a_neg ^ b_neg;
      sign_r_q <= a_neg;
    end else if (state_q == CALC) begin
      quo_q   <= quo_step;
      rem_q   <= rem_step;
      count_q <= count_q - 1'b1;
    end
  end

  // Result registers load on entry to DONE so the pulse and data come straight from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_vld_q <= 1'b0;
      dout_dat_q <= '0;
    end else begin
      dout_vld_q <= (state_d == DONE);
      if (state_d == DONE) dout_dat_q <= {res_quo, res_rem};
    end
  end

endmodule

// File: tb/tb_axis_iter_div.sv
// Bench for axis_iter_div: signed and unsigned instances checked against an arithmetic reference model.
// Latency: checks result pulse cycle, tready busy window and data hold after the pulse.
// Backpressure: drives half handshakes, flush and reset mid-operation.
module tb_axis_iter_div;

`ifdef DIV_FASTPATH_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush_s = 1'b0;
  logic flush_u = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  axis_iter_div_if #(.WIDTH(32)) bus_s ();
  axis_iter_div_if #(.WIDTH(32)) bus_u ();

  axis_iter_div #(.SIGNED(1'b1), .WIDTH(32)) u_div  (.clk(clk), .rst(rst), .flush(flush_s), .bus(bus_s));
  axis_iter_div #(.SIGNED(1'b0), .WIDTH(32)) u_divu (.clk(clk), .rst(rst), .flush(flush_u), .bus(bus_u));

  // sel=1 addresses the signed instance, sel=0 the unsigned one.
  task automatic set_in(input bit sel, input logic va, input logic vb, input logic [31:0] a, input logic [31:0] b);
    if (sel) begin
      bus_s.s_axis_dividend_tvalid = va; bus_s.s_axis_divisor_tvalid = vb;
      bus_s.s_axis_dividend_tdata  = a;  bus_s.s_axis_divisor_tdata  = b;
    end else begin
      bus_u.s_axis_dividend_tvalid = va; bus_u.s_axis_divisor_tvalid = vb;
      bus_u.s_axis_dividend_tdata  = a;  bus_u.s_axis_divisor_tdata  = b;
    end
  endtask

  function automatic logic get_vld(input bit sel);
    return sel ? bus_s.m_axis_dout_tvalid : bus_u.m_axis_dout_tvalid;
  endfunction
  function automatic logic get_rdy(input bit sel);
    return sel ? (bus_s.s_axis_dividend_tready & bus_s.s_axis_divisor_tready)
               : (bus_u.s_axis_dividend_tready & bus_u.s_axis_divisor_tready);
  endfunction
  function automatic logic get_rdy_any(input bit sel);
    return sel ? (bus_s.s_axis_dividend_tready | bus_s.s_axis_divisor_tready)
               : (bus_u.s_axis_dividend_tready | bus_u.s_axis_divisor_tready);
  endfunction
  function automatic logic [63:0] get_dat(input bit sel);
    return sel ? bus_s.m_axis_dout_tdata : bus_u.m_axis_dout_tdata;
  endfunction

  // Reference: truncating division; divide-by-zero gives all-ones magnitude quotient and the dividend as remainder.
  function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [31:0] q32, r32;
    if (!sgn) begin
      if (b == 0) begin q32 = 32'hFFFF_FFFF; r32 = a; end
      else begin q32 = a / b; r32 = a % b; end
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (sb == 0) begin
        q32 = (sa < 0) ? 32'h0000_0001 : 32'hFFFF_FFFF;
        r32 = a;
      end else begin
        q = sa / sb; r = sa % sb;
        q32 = q[31:0]; r32 = r[31:0];
      end
    end
    return {q32, r32};
  endfunction

  function automatic bit fast_cond(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint ma, mb;
    if (sgn) begin
      ma = longint'($signed(a)); mb = longint'($signed(b));
      if (ma < 0) ma = -ma;
      if (mb < 0) mb = -mb;
    end else begin
      ma = longint'({32'd0, a}); mb = longint'({32'd0, b});
    end
    return (mb == 0) || (ma < mb);
  endfunction

  // Called at a negedge with tready expected high; returns at the negedge of the cycle after the pulse.
  task automatic run_op(input bit sel, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [63:0] exp;
    int exp_lat, lat, busy_bad;
    exp     = model(sel, a, b);
    exp_lat = (FAST && fast_cond(sel, a, b)) ? 1 : 33;
    set_in(sel, 1'b1, 1'b1, a, b);
    n_cmp++;
    if (get_rdy(sel) !== 1'b1) begin n_bad++; $display("FAIL %s rdy_at_start: got %b want 1", tag, get_rdy(sel)); end
    lat = 0; busy_bad = 0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (k == 1) set_in(sel, 1'b0, 1'b0, $urandom, $urandom);
      if (get_rdy_any(sel) !== 1'b0) busy_bad++;
      if (get_vld(sel) === 1'b1) begin lat = k; break; end
    end
    n_cmp++;
    if (lat == 0) begin
      n_bad++; $display("FAIL %s timeout: no pulse within 80 cycles, want cycle %0d", tag, exp_lat);
    end else begin
      if (lat != exp_lat) begin n_bad++; $display("FAIL %s latency: got %0d want %0d", tag, lat, exp_lat); end
      n_cmp++;
      if (get_dat(sel) !== exp) begin n_bad++; $display("FAIL %s tdata: got %h want %h", tag, get_dat(sel), exp); end
      n_cmp++;
      if (busy_bad != 0) begin n_bad++; $display("FAIL %s busy_rdy: got %0d ready cycles want 0", tag, busy_bad); end
    end
    @(negedge clk);
    n_cmp++;
    if (get_vld(sel) !== 1'b0 || get_rdy(sel) !== 1'b1) begin
      n_bad++; $display("FAIL %s after_pulse: got vld=%b rdy=%b want vld=0 rdy=1", tag, get_vld(sel), get_rdy(sel));
    end
    n_cmp++;
    if (get_dat(sel) !== exp) begin n_bad++; $display("FAIL %s hold: got %h want %h", tag, get_dat(sel), exp); end
  endtask

  // Watches both instances for a stray pulse.
  task automatic expect_quiet(input int cycles, input string tag);
    int seen = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (bus_s.m_axis_dout_tvalid !== 1'b0 || bus_u.m_axis_dout_tvalid !== 1'b0) seen++;
    end
    n_cmp++;
    if (seen != 0) begin n_bad++; $display("FAIL %s stray_pulse: got %0d pulse cycles want 0", tag, seen); end
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      5: return 32'($urandom_range(0, 2000)) - 32'd1000;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_reset();
    set_in(1'b1, 1'b0, 1'b0, '0, '0);
    set_in(1'b0, 1'b0, 1'b0, '0, '0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      n_cmp++;
      if (get_rdy_any(s[0]) !== 1'b0 || get_vld(s[0]) !== 1'b0 || get_dat(s[0]) !== 64'h0) begin
        n_bad++;
        $display("FAIL reset_state[%0d]: got rdy=%b vld=%b dat=%h want 0/0/0", s, get_rdy_any(s[0]), get_vld(s[0]), get_dat(s[0]));
      end
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (get_rdy(1'b1) !== 1'b1 || get_rdy(1'b0) !== 1'b1) begin
      n_bad++; $display("FAIL reset_release_rdy: got %b%b want 11", get_rdy(1'b1), get_rdy(1'b0));
    end
    @(negedge clk);
  endtask

  task automatic test_directed();
    run_op(1'b0, 32'd100, 32'd7, "divu_100_7");
    n_cmp++;
    if (get_dat(1'b0) !== 64'h0000000E_00000002) begin
      n_bad++; $display("FAIL const_100_7: got %h want 0000000e00000002", get_dat(1'b0));
    end
    run_op(1'b1, 32'hFFFF_FFF9, 32'h2, "div_m7_2");
    n_cmp++;
    if (get_dat(1'b1) !== 64'hFFFFFFFD_FFFFFFFF) begin
      n_bad++; $display("FAIL const_m7_2: got %h want fffffffdffffffff", get_dat(1'b1));
    end
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
    n_cmp++;
    if (get_dat(1'b1) !== 64'h80000000_00000000) begin
      n_bad++; $display("FAIL const_overflow: got %h want 8000000000000000", get_dat(1'b1));
    end
    run_op(1'b0, 32'd5, 32'd0, "divu_5_0");
    n_cmp++;
    if (get_dat(1'b0) !== 64'hFFFFFFFF_00000005) begin
      n_bad++; $display("FAIL const_5_0: got %h want ffffffff00000005", get_dat(1'b0));
    end
    run_op(1'b1, 32'hFFFF_FFFB, 32'd0, "div_m5_0");
    n_cmp++;
    if (get_dat(1'b1) !== 64'h00000001_FFFFFFFB) begin
      n_bad++; $display("FAIL const_m5_0: got %h want 00000001fffffffb", get_dat(1'b1));
    end
    run_op(1'b0, 32'd3, 32'd10, "divu_3_10");
    n_cmp++;
    if (get_dat(1'b0) !== 64'h00000000_00000003) begin
      n_bad++; $display("FAIL const_3_10: got %h want 0000000000000003", get_dat(1'b0));
    end
  endtask

  task automatic test_half_handshake();
    int bad = 0;
    set_in(1'b0, 1'b1, 1'b0, 32'd77, 32'd5);
    repeat (5) begin
      @(negedge clk);
      if (get_rdy(1'b0) !== 1'b1 || get_vld(1'b0) !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin n_bad++; $display("FAIL half_handshake: got %0d bad cycles want 0", bad); end
    run_op(1'b0, 32'd77, 32'd5, "half_then_full");
  endtask

  task automatic test_flush();
    set_in(1'b1, 1'b1, 1'b1, 32'd1000, 32'd7);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) set_in(1'b1, 1'b0, 1'b0, '0, '0);
    end
    flush_s = 1'b1;
    @(negedge clk);
    flush_s = 1'b0;
    #1;
    n_cmp++;
    if (get_rdy(1'b1) !== 1'b1) begin n_bad++; $display("FAIL flush_rdy: got %b want 1", get_rdy(1'b1)); end
    expect_quiet(40, "flush");
    run_op(1'b1, 32'd9, 32'd3, "after_flush");
  endtask

  task automatic test_reset_mid();
    logic [63:0] pre;
    pre = get_dat(1'b0);
    set_in(1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'd13);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) set_in(1'b0, 1'b0, 1'b0, '0, '0);
    end
    rst = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      n_cmp++;
      if (get_rdy_any(s[0]) !== 1'b0 || get_vld(s[0]) !== 1'b0 || get_dat(s[0]) !== 64'h0) begin
        n_bad++;
        $display("FAIL mid_reset[%0d]: got rdy=%b vld=%b dat=%h want 0/0/0 (prior dat %h)", s, get_rdy_any(s[0]), get_vld(s[0]), get_dat(s[0]), pre);
      end
    end
    rst = 1'b0;
    expect_quiet(40, "mid_reset");
    run_op(1'b0, 32'hDEAD_BEEF, 32'd13, "after_reset");
  endtask

  task automatic test_back_to_back();
    run_op(1'b1, 32'd1234567, 32'hFFFF_FF85, "b2b_0");
    run_op(1'b1, 32'hFFF0_0000, 32'd3, "b2b_1");
    run_op(1'b1, 32'd0, 32'd9, "b2b_2");
    run_op(1'b1, 32'd42, 32'd42, "b2b_3");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      bit sel;
      logic [31:0] a, b;
      sel = i[0];
      a = rnd_op();
      b = rnd_op();
      run_op(sel, a, b, $sformatf("rand%0d_%0d_%h_%h", i, sel, a, b));
    end
  endtask

  initial begin
    set_in(1'b1, 1'b0, 1'b0, '0, '0);
    set_in(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    test_reset();
    test_directed();
    test_half_handshake();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard stop so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
